// File: rtl/dio24_leds_btn_pwm_if.sv
// rtl/dio24_leds_btn_pwm_if.sv - button and LED signal bundle for dio24_leds_btn_pwm
interface dio24_leds_btn_pwm_if #(
    parameter int NUM_BUTTONS = 2,
    parameter int NUM_LEDS    = 2,
    parameter int PWM_BITS    = 8
);
    logic [NUM_BUTTONS-1:0]       btn_in;
    logic [NUM_BUTTONS-1:0]       btn_status;
    logic [NUM_BUTTONS-1:0]       btn_press;
    logic [NUM_BUTTONS-1:0]       btn_release;
    logic [NUM_BUTTONS-1:0]       btn_long;
    logic [NUM_LEDS-1:0]          leds_in;
    logic [NUM_LEDS*PWM_BITS-1:0] leds_duty;
    logic [NUM_LEDS-1:0]          leds_blink;
    logic [NUM_LEDS*2-1:0]        leds_period;
    logic [NUM_LEDS-1:0]          leds_inv;
    logic [NUM_LEDS-1:0]          leds_out;

    modport master (
        output btn_in, leds_in, leds_duty, leds_blink, leds_period, leds_inv,
        input  btn_status, btn_press, btn_release, btn_long, leds_out
    );

    modport slave (
        input  btn_in, leds_in, leds_duty, leds_blink, leds_period, leds_inv,
        output btn_status, btn_press, btn_release, btn_long, leds_out
    );
endinterface

// File: rtl/dio24_leds_btn_pwm.sv
// rtl/dio24_leds_btn_pwm.sv - debounced buttons with press/release/long events, PWM/blink LEDs
module dio24_leds_btn_pwm #(
    parameter int NUM_BUTTONS   = 2,
    parameter int NUM_LEDS      = 2,
    parameter int BTN_SYNC      = 2,
    parameter int BTN_DEB_BITS  = 10,
    parameter int BTN_LONG_BITS = 26,
    parameter int PWM_BITS      = 8,
    parameter int BLINK_BITS    = 26
) (
    input  logic                  clk,
    input  logic                  reset_n,
    dio24_leds_btn_pwm_if.slave   bus
);

    logic [BLINK_BITS-1:0] r_cnt;
    logic [3:0]            w_cnt_top;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_cnt <= '0;
        else          r_cnt <= r_cnt + 1'b1;
    end

    assign w_cnt_top = r_cnt[BLINK_BITS-1 -: 4];

    logic [NUM_LEDS-1:0] r_leds_ff;
    logic [NUM_LEDS-1:0] r_leds_stage;
    logic [NUM_LEDS-1:0] r_leds_out;
    logic [NUM_LEDS-1:0] w_pwm_on;
    logic [NUM_LEDS-1:0] w_blink_on;

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_led
        logic [PWM_BITS-1:0] w_duty;
        logic [1:0]          w_sel;
        assign w_duty        = bus.leds_duty[g*PWM_BITS +: PWM_BITS];
        assign w_sel         = bus.leds_period[2*g +: 2];
        // all-ones duty is fully on; otherwise the compare would leave one dark slot
        assign w_pwm_on[g]   = (&w_duty) | (r_cnt[PWM_BITS-1:0] < w_duty);
        // ~sel picks counter bit BLINK_BITS-1-sel out of the top nibble
        assign w_blink_on[g] = ~bus.leds_blink[g] | ~w_cnt_top[~w_sel];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_leds_ff    <= '0;
            r_leds_stage <= '0;
            r_leds_out   <= '0;
        end else begin
            r_leds_ff    <= bus.leds_in;
            r_leds_stage <= (r_leds_ff & w_pwm_on & w_blink_on) ^ bus.leds_inv;
            r_leds_out   <= r_leds_stage;
        end
    end

    assign bus.leds_out = r_leds_out;

    logic [NUM_BUTTONS-1:0] w_sig;

    if (BTN_SYNC == 0) begin : g_nosync
        assign w_sig = bus.btn_in;
    end else begin : g_sync
        logic [NUM_BUTTONS-1:0] r_sync [BTN_SYNC];
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < BTN_SYNC; i++) r_sync[i] <= '0;
            end else begin
                r_sync[0] <= bus.btn_in;
                for (int i = 1; i < BTN_SYNC; i++) r_sync[i] <= r_sync[i-1];
            end
        end
        assign w_sig = r_sync[BTN_SYNC-1];
    end

    for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
        logic [BTN_DEB_BITS-1:0]  r_dcnt;
        logic [BTN_LONG_BITS-1:0] r_lcnt;
        logic                     r_state;
        logic                     r_long_done;
        logic                     r_press;
        logic                     r_release;
        logic                     r_long;
        logic                     w_diff;
        logic                     w_flip;

        assign w_diff = w_sig[b] ^ r_state;
        assign w_flip = w_diff & (&r_dcnt);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_dcnt      <= '0;
                r_lcnt      <= '0;
                r_state     <= 1'b0;
                r_long_done <= 1'b0;
                r_press     <= 1'b0;
                r_release   <= 1'b0;
                r_long      <= 1'b0;
            end else begin
                r_press   <= w_flip & w_sig[b];
                r_release <= w_flip & ~w_sig[b];
                r_long    <= 1'b0;
                if (w_diff && !w_flip) r_dcnt <= r_dcnt + 1'b1;
                else                   r_dcnt <= '0;
                if (w_flip) begin
                    r_state     <= w_sig[b];
                    r_lcnt      <= '0;
                    r_long_done <= 1'b0;
                end else if (r_state) begin
                    // lcnt holds at max; long_done limits the pulse to once per press
                    if (&r_lcnt) begin
                        if (!r_long_done) begin
                            r_long      <= 1'b1;
                            r_long_done <= 1'b1;
                        end
                    end else begin
                        r_lcnt <= r_lcnt + 1'b1;
                    end
                end
            end
        end

        assign bus.btn_status[b]  = r_state;
        assign bus.btn_press[b]   = r_press;
        assign bus.btn_release[b] = r_release;
        assign bus.btn_long[b]    = r_long;
    end

endmodule

// File: tb/tb_dio24_leds_btn_pwm.sv
// tb/tb_dio24_leds_btn_pwm.sv - self-checking bench for dio24_leds_btn_pwm
module tb_dio24_leds_btn_pwm;

    localparam int MAXE = 8192;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dio24_leds_btn_pwm_if #(.NUM_BUTTONS(2), .NUM_LEDS(2), .PWM_BITS(4)) bus();

    dio24_leds_btn_pwm #(
        .NUM_BUTTONS(2), .NUM_LEDS(2), .BTN_SYNC(2), .BTN_DEB_BITS(3),
        .BTN_LONG_BITS(5), .PWM_BITS(4), .BLINK_BITS(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    typedef struct {
        string      name;
        logic [1:0] leds;
        logic [7:0] duty;
        logic [1:0] blink;
        logic [3:0] per;
        logic [1:0] inv;
        logic [1:0] btn;
        int         cycles;
        int         exp_on0;
        int         exp_press0;
        int         exp_rel0;
        int         exp_long0;
    } vec_t;

    vec_t tbl[$];

    int checks = 0;
    int errors = 0;
    int k = 0;

    logic [1:0] h_btn [MAXE];
    logic [1:0] h_leds[MAXE];
    logic [1:0] h_blink[MAXE];
    logic [1:0] h_inv [MAXE];
    logic [7:0] h_duty[MAXE];
    logic [3:0] h_per [MAXE];

    bit m_state[2];
    int m_press_edge[2] = '{-1000, -1000};
    logic [1:0] e_status, e_press, e_rel, e_long, e_leds;

    function automatic vec_t mk(string n, logic [1:0] l, logic [7:0] d, logic [1:0] bl,
                                logic [3:0] p, logic [1:0] iv, logic [1:0] b, int c,
                                int on0, int pr, int rl, int lg);
        vec_t v;
        v.name = n; v.leds = l; v.duty = d; v.blink = bl; v.per = p; v.inv = iv;
        v.btn = b; v.cycles = c; v.exp_on0 = on0; v.exp_press0 = pr;
        v.exp_rel0 = rl; v.exp_long0 = lg;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, k, act, exp);
        end
    endtask

    function automatic bit sig_at(int j, int b);
        if (j - 2 >= 1) return h_btn[j-2][b];
        return 1'b0;
    endfunction

    // LED level after edge kk: stage computed one edge earlier from inputs captured then
    function automatic bit led_model(int kk, int i);
        int j, c, duty, s;
        bit ff, pwm, blk;
        j = kk - 1;
        if (j < 1) return 1'b0;
        ff   = (j - 1 >= 1) ? h_leds[j-1][i] : 1'b0;
        c    = (j - 1) % 256;
        duty = (int'(h_duty[j]) >> (4*i)) & 15;
        s    = (int'(h_per[j]) >> (2*i)) & 3;
        pwm  = (duty == 15) || ((c % 16) < duty);
        blk  = !h_blink[j][i] || ((c % (256 >> s)) < (128 >> s));
        return (ff & pwm & blk) ^ h_inv[j][i];
    endfunction

    task automatic tick();
        bit flip;
        @(posedge clk);
        k++;
        h_btn[k] = bus.btn_in; h_leds[k] = bus.leds_in; h_blink[k] = bus.leds_blink;
        h_inv[k] = bus.leds_inv; h_duty[k] = bus.leds_duty; h_per[k] = bus.leds_period;
        e_press = '0; e_rel = '0; e_long = '0;
        for (int b = 0; b < 2; b++) begin
            // a new level must be seen on 8 consecutive edges before it is accepted
            flip = 1'b1;
            for (int j = k - 7; j <= k; j++) if (sig_at(j, b) == m_state[b]) flip = 1'b0;
            if (!flip && m_state[b] && (k - m_press_edge[b] == 32)) e_long[b] = 1'b1;
            if (flip) begin
                m_state[b] = ~m_state[b];
                if (m_state[b]) begin e_press[b] = 1'b1; m_press_edge[b] = k; end
                else e_rel[b] = 1'b1;
            end
            e_status[b] = m_state[b];
            e_leds[b] = led_model(k, b);
        end
        #1;
        chk("leds_out", int'(bus.leds_out), int'(e_leds));
        chk("btn_status", int'(bus.btn_status), int'(e_status));
        chk("btn_press", int'(bus.btn_press), int'(e_press));
        chk("btn_release", int'(bus.btn_release), int'(e_rel));
        chk("btn_long", int'(bus.btn_long), int'(e_long));
    endtask

    int on0, pr0, rl0, lg0;
    int hold[2];

    initial begin
        bus.btn_in = 2'b11; bus.leds_in = 2'b11; bus.leds_inv = 2'b11;
        bus.leds_duty = 8'hFF; bus.leds_blink = 2'b00; bus.leds_period = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_leds_out", int'(bus.leds_out), 0);
        chk("rst_btn_status", int'(bus.btn_status), 0);
        chk("rst_btn_press", int'(bus.btn_press), 0);
        chk("rst_btn_release", int'(bus.btn_release), 0);
        chk("rst_btn_long", int'(bus.btn_long), 0);

        reset_n = 1'b1;
        tick(); chk("rel_e1", int'(bus.leds_out), 0);
        tick(); chk("rel_e2", int'(bus.leds_out), 3);
        tick(); chk("rel_e3", int'(bus.leds_out), 0);
        tick(); chk("rel_e4", int'(bus.leds_out), 0);
        bus.btn_in = 2'b00;

        bus.leds_in = 2'b00; bus.leds_inv = 2'b01;
        repeat (5) tick();
        bus.leds_in = 2'b01;
        tick(); chk("inv_lat1", int'(bus.leds_out[0]), 1);
        tick(); chk("inv_lat2", int'(bus.leds_out[0]), 1);
        tick(); chk("inv_lat3", int'(bus.leds_out[0]), 0);

        tbl.push_back(mk("pwm4",       2'b11, 8'h94, 2'b00, 4'h0, 2'b00, 2'b00, 48,  8, 0, 0, 0));
        tbl.push_back(mk("pwm15",      2'b11, 8'h0F, 2'b00, 4'h0, 2'b00, 2'b00, 40, 32, 0, 0, 0));
        tbl.push_back(mk("pwm0",       2'b11, 8'h00, 2'b00, 4'h0, 2'b00, 2'b00, 40,  0, 0, 0, 0));
        tbl.push_back(mk("blink_s3",   2'b11, 8'hFF, 2'b11, 4'hF, 2'b00, 2'b00, 64, 16, 0, 0, 0));
        tbl.push_back(mk("blink_s0",   2'b11, 8'hFF, 2'b11, 4'h0, 2'b00, 2'b00, 300, -1, 0, 0, 0));
        tbl.push_back(mk("blink_s1",   2'b11, 8'hFF, 2'b11, 4'h5, 2'b00, 2'b00, 200, -1, 0, 0, 0));
        tbl.push_back(mk("inv_idle",   2'b00, 8'hFF, 2'b00, 4'h0, 2'b11, 2'b00, 40, 32, 0, 0, 0));
        tbl.push_back(mk("inv_on",     2'b11, 8'hFF, 2'b00, 4'h0, 2'b11, 2'b00, 40,  0, 0, 0, 0));
        tbl.push_back(mk("bounce",     2'b11, 8'hFF, 2'b00, 4'h0, 2'b00, 2'b01,  7, -1, 0, 0, 0));
        tbl.push_back(mk("low",        2'b11, 8'hFF, 2'b00, 4'h0, 2'b00, 2'b00, 20, -1, 0, 0, 0));
        tbl.push_back(mk("press_long", 2'b11, 8'hFF, 2'b00, 4'h0, 2'b00, 2'b11, 50, 32, 1, 0, 1));
        tbl.push_back(mk("release",    2'b11, 8'hFF, 2'b00, 4'h0, 2'b00, 2'b00, 20, -1, 0, 1, 0));
        tbl.push_back(mk("short_pr",   2'b11, 8'hFF, 2'b00, 4'h0, 2'b00, 2'b01, 30, -1, 1, 0, 0));
        tbl.push_back(mk("release2",   2'b11, 8'hFF, 2'b00, 4'h0, 2'b00, 2'b00, 20, -1, 0, 1, 0));
        tbl.push_back(mk("press_b1",   2'b11, 8'hFF, 2'b00, 4'h0, 2'b00, 2'b10, 20, -1, 0, 0, 0));
        tbl.push_back(mk("rel_b1",     2'b11, 8'hFF, 2'b00, 4'h0, 2'b00, 2'b00, 20, -1, 0, 0, 0));

        foreach (tbl[t]) begin
            bus.leds_in = tbl[t].leds; bus.leds_duty = tbl[t].duty;
            bus.leds_blink = tbl[t].blink; bus.leds_period = tbl[t].per;
            bus.leds_inv = tbl[t].inv; bus.btn_in = tbl[t].btn;
            on0 = 0; pr0 = 0; rl0 = 0; lg0 = 0;
            for (int c = 0; c < tbl[t].cycles; c++) begin
                tick();
                if (c >= tbl[t].cycles - 32) on0 += int'(bus.leds_out[0]);
                pr0 += int'(bus.btn_press[0]);
                rl0 += int'(bus.btn_release[0]);
                lg0 += int'(bus.btn_long[0]);
            end
            if (tbl[t].exp_on0 >= 0) chk({tbl[t].name, "_on0"}, on0, tbl[t].exp_on0);
            chk({tbl[t].name, "_press0"}, pr0, tbl[t].exp_press0);
            chk({tbl[t].name, "_rel0"}, rl0, tbl[t].exp_rel0);
            chk({tbl[t].name, "_long0"}, lg0, tbl[t].exp_long0);
        end

        hold = '{0, 0};
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 2; b++) begin
                if (hold[b] == 0) begin
                    bus.btn_in[b] = 1'($urandom_range(0, 1));
                    hold[b] = (($urandom_range(0, 3) == 0) ? 40 : 1) + $urandom_range(0, 13);
                end else begin
                    hold[b]--;
                end
            end
            if ($urandom_range(0, 15) == 0) begin
                bus.leds_in = 2'($urandom); bus.leds_duty = 8'($urandom);
                bus.leds_blink = 2'($urandom); bus.leds_period = 4'($urandom);
                bus.leds_inv = 2'($urandom);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dio24_leds_btn_pwm.md
Name: dio24_leds_btn_pwm

Overview:
Second-generation LED/button I/O block for the dio24 board. It debounces NUM_BUTTONS buttons with a symmetric stable-time filter and emits press, release and long-press event pulses. It drives NUM_LEDS LEDs, each with a runtime-programmable PWM duty, blink period select and inversion. It sits between the board pins and the dio24 control registers, which supply the per-LED configuration and consume the button events.

Parameters:
NUM_BUTTONS, 2, number of buttons
NUM_LEDS, 2, number of LEDs
BTN_SYNC, 2, synchronizer flops per button; 0 = no synchronizer
BTN_DEB_BITS, 10, debounce stable time = 2^BTN_DEB_BITS cycles (>=1)
BTN_LONG_BITS, 26, long-press time = 2^BTN_LONG_BITS cycles (>=1)
PWM_BITS, 8, duty resolution (>=1)
BLINK_BITS, 26, free-running counter width; must be >= PWM_BITS+4

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
btn_in  in  NUM_BUTTONS  raw button levels
btn_status  out  NUM_BUTTONS  debounced level
btn_press  out  NUM_BUTTONS  1-cycle pulse on debounced 0->1
btn_release  out  NUM_BUTTONS  1-cycle pulse on debounced 1->0
btn_long  out  NUM_BUTTONS  1-cycle pulse once per press after the long-press time
leds_in  in  NUM_LEDS  LED on/off request
leds_duty  in  NUM_LEDS*PWM_BITS  per-LED duty, LED i in bits [i*PWM_BITS +: PWM_BITS]
leds_blink  in  NUM_LEDS  1 = blink enabled
leds_period  in  NUM_LEDS*2  blink period select s, LED i in bits [2i +: 2]
leds_inv  in  NUM_LEDS  1 = invert final LED signal
leds_out  out  NUM_LEDS  LED pin drive (IOB register)

Behaviour:
- Reset is asynchronous and active-low: all registers clear while reset_n=0, including the counter, synchronizers, debounce/long counters, all outputs and both LED pipeline stages. leds_out=0 during reset even when leds_inv=1. Inversion takes effect 2 edges after release.
- cnt[BLINK_BITS-1:0] increments every cycle and wraps freely.
- PWM: pwm_on = (cnt[PWM_BITS-1:0] < duty), with one exception: duty = all-ones gives pwm_on=1 constantly. duty=0 gives constant off.
- Blink: blink_on = ~leds_blink[i] | ~cnt[BLINK_BITS-1-s]. This is a 50% ratio with period 2^(BLINK_BITS-s) cycles, s=0..3.
- LED pipeline:
  - edge 1: leds_in registered.
  - edge 2: stage reg = (leds_ff & pwm_on & blink_on) ^ leds_inv, using the cnt value before the edge.
  - edge 3: IOB register drives leds_out.
  - leds_in to leds_out latency = 3 edges.
  - Config inputs (duty, blink, period, inv) are sampled unregistered at edge 2, giving 2-edge latency.
  - Config changes do not reset cnt.
- Button sync: a chain of BTN_SYNC flops produces sig. With BTN_SYNC=0, sig = btn_in.
- Debounce per button:
  - Counter dcnt counts while sig != state and clears whenever sig == state.
  - When sig != state and dcnt = 2^BTN_DEB_BITS-1, state flips and dcnt clears.
  - A clean edge therefore appears on btn_status exactly BTN_SYNC + 2^BTN_DEB_BITS edges after the first edge that samples the new level.
  - Bounces shorter than the stable time produce no change.
  - The filter is symmetric for press and release.
- btn_press and btn_release are registered on the same edge as the state flip and last exactly 1 cycle.
- Long press:
  - lcnt clears at the press flip and increments while state=1, saturating at its maximum.
  - btn_long pulses 1 cycle at edge 2^BTN_LONG_BITS after the press edge; at most once per press.
  - Release clears lcnt, and btn_long is never asserted after release.
- Buttons and LEDs are independent per index; simultaneous events on different indices are all reported in the same cycle.

Test Plan:
Common parameters: BTN_SYNC=2, BTN_DEB_BITS=3, BTN_LONG_BITS=5, PWM_BITS=4, BLINK_BITS=8.
1. Reset: reset_n=0 with btn_in=all1, leds_in=all1, leds_inv=all1 -> all outputs 0. Release reset -> cnt starts at 0; leds_out follows the pipeline from edge 2 on.
2. PWM: leds_in=1, blink=0, inv=0, duty=4 -> leds_out high exactly 4 of every 16 cycles, aligned to cnt[3:0] in 0..3 with 2-edge delay. duty=15 -> constant 1. duty=0 -> constant 0.
3. Blink: duty=15, blink=1. s=0 -> 128 cycles on / 128 off. s=3 -> 16 on / 16 off. The phase is unchanged when s switches.
4. Inversion/latency: duty=15, inv=1, leds_in 0->1 -> leds_out 1->0 exactly 3 edges after leds_in is sampled.
5. Debounce:
   - btn_in high for 7 cycles, then low -> btn_status stays 0, no pulses.
   - btn_in held high -> btn_status rises on edge 10 after first sampling; btn_press pulses 1 cycle on the same edge.
   - Release held low -> btn_status falls after 10 edges; btn_release pulses.
6. Long press: hold 40 cycles after btn_press -> single btn_long pulse 32 edges after btn_press, no repeat. A second press released after 20 cycles -> no btn_long.
